// File: rtl/cbus_arb_pkg.sv
// Arbiter-local types: FSM states, master index type and the round-robin wrap helper.
package cbus_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef logic [2:0] master_idx_t;

  localparam int MAX_MASTERS = 8;

  function automatic master_idx_t rr_next(input master_idx_t idx, input int unsigned n);
    master_idx_t nxt;
    if (({29'd0, idx} + 32'd1) >= n) begin
      nxt = 3'd0;
    end else begin
      nxt = idx + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cbus_pkg.sv
// Shared cache-bus request/response types used by the caches, the arbiter and the memory side.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_chk.sv
// Simulation checker for the arbiter: the owner must keep valid high for its whole transaction.
module cbus_arbiter_chk (
  input logic clk,
  input logic resetn,
  input logic busy,
  input logic owner_valid
);

  owner_holds_valid: assert property (@(posedge clk) disable iff (!resetn) busy |-> owner_valid);

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_picker
  import cbus_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  master_idx_t  ptr,
  output logic         found,
  output master_idx_t  idx
);

  localparam int SUM_W = $clog2(2 * MAX_MASTERS);

  logic [2*N-1:0]   dbl_s;
  logic [N-1:0]     rot_s;
  logic [SUM_W-1:0] off_s;
  logic [SUM_W-1:0] sum_s;

  // Rotate so ptr lands on bit 0, then take the lowest set offset
  always_comb begin
    found = 1'b0;
    off_s = '0;
    dbl_s = {req, req};
    rot_s = N'(dbl_s >> ptr);
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        found = 1'b1;
        off_s = SUM_W'(k);
      end else begin
        off_s = off_s;
      end
    end
    sum_s = SUM_W'(ptr) + off_s;
    if (sum_s >= SUM_W'(N)) begin
      idx = master_idx_t'(sum_s - SUM_W'(N));
    end else begin
      idx = master_idx_t'(sum_s);
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter merging NUM_MASTERS cbus requesters onto one memory-side port.
// Optional CBUS_ARB_PERF_EN adds completed-transaction and wait-cycle counters.
module cbus_arbiter
  import cbus_pkg::*;
  import cbus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  cbus_req_t   ireqs  [NUM_MASTERS],
  output cbus_resp_t  oresps [NUM_MASTERS],
  output cbus_req_t   oreq,
  input  cbus_resp_t  iresp
`ifdef CBUS_ARB_PERF_EN
  ,
  output logic [31:0] perf_txns,
  output logic [31:0] perf_wait
`endif
);

  arb_state_t             state_r;
  arb_state_t             state_nxt_s;
  master_idx_t            sel_r;
  master_idx_t            sel_nxt_s;
  master_idx_t            rr_ptr_r;
  master_idx_t            rr_ptr_nxt_s;
  logic [NUM_MASTERS-1:0] valid_vec_s;
  logic                   pick_found_s;
  master_idx_t            pick_idx_s;
  logic                   last_hs_s;
  logic                   owner_valid_s;

  // Gather request valids for the picker
  always_comb begin
    valid_vec_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      valid_vec_s[i] = ireqs[i].valid;
    end
  end

  rr_picker #(
    .N(NUM_MASTERS)
  ) u_picker (
    .req  (valid_vec_s),
    .ptr  (rr_ptr_r),
    .found(pick_found_s),
    .idx  (pick_idx_s)
  );

  assign last_hs_s = (state_r == ARB_BUSY) & iresp.ready & iresp.last;

  // Arbitration state, current owner and round-robin pointer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ARB_IDLE;
      sel_r    <= 3'd0;
      rr_ptr_r <= 3'd0;
    end else begin
      state_r  <= state_nxt_s;
      sel_r    <= sel_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  // Next state: grant from IDLE, release on the owner's last beat
  always_comb begin
    state_nxt_s  = state_r;
    sel_nxt_s    = sel_r;
    rr_ptr_nxt_s = rr_ptr_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_found_s) begin
          state_nxt_s = ARB_BUSY;
          sel_nxt_s   = pick_idx_s;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        // The returning master drops to lowest priority for the next round
        if (last_hs_s) begin
          state_nxt_s  = ARB_IDLE;
          rr_ptr_nxt_s = rr_next(sel_r, NUM_MASTERS);
        end else begin
          state_nxt_s = ARB_BUSY;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // Bus mux: select comes only from registered state, responses go to the owner only
  always_comb begin
    oreq          = '0;
    owner_valid_s = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      oresps[i] = '0;
    end
    if (state_r == ARB_BUSY) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (sel_r == master_idx_t'(i)) begin
          oreq          = ireqs[i];
          oresps[i]     = iresp;
          owner_valid_s = ireqs[i].valid;
        end else begin
          oresps[i] = '0;
        end
      end
    end else begin
      oreq = '0;
    end
  end

`ifdef CBUS_ARB_PERF_EN
  logic        wait_s;
  logic [31:0] perf_txns_r;
  logic [31:0] perf_wait_r;

  // A cycle counts as waiting when any master other than the owner is requesting
  always_comb begin
    wait_s = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (ireqs[i].valid && ((state_r == ARB_IDLE) || (sel_r != master_idx_t'(i)))) begin
        wait_s = 1'b1;
      end else begin
        wait_s = wait_s;
      end
    end
  end

  // Wrapping performance counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_txns_r <= 32'd0;
      perf_wait_r <= 32'd0;
    end else begin
      perf_txns_r <= perf_txns_r + {31'd0, last_hs_s};
      perf_wait_r <= perf_wait_r + {31'd0, wait_s};
    end
  end

  assign perf_txns = perf_txns_r;
  assign perf_wait = perf_wait_r;
`endif

`ifndef SYNTHESIS
  cbus_arbiter_chk u_chk (
    .clk        (clk),
    .resetn     (resetn),
    .busy       (state_r == ARB_BUSY),
    .owner_valid(owner_valid_s)
  );
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter: expected grants queued at stimulus time, popped at each bus grant.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int NM    = 2;
  localparam int BOUND = 200;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [7:0]  len;
    int          gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  ireqs  [NM];
  cbus_resp_t oresps [NM];
  cbus_req_t  oreq;
  cbus_resp_t iresp;
`ifdef CBUS_ARB_PERF_EN
  logic [31:0] perf_txns;
  logic [31:0] perf_wait;
`endif

  exp_t       exp_q[$];
  int         check_cnt = 0;
  int         err_cnt   = 0;
  bit         gap_mode  = 1'b0;
  logic [7:0] lens [10];

  always #5 clk = ~clk;

  cbus_arbiter #(
    .NUM_MASTERS(NM)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .ireqs (ireqs),
    .oresps(oresps),
    .oreq  (oreq),
    .iresp (iresp)
`ifdef CBUS_ARB_PERF_EN
    ,
    .perf_txns(perf_txns),
    .perf_wait(perf_wait)
`endif
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic cbus_req_t mk_req(input logic [31:0] addr, input logic wr, input logic [7:0] len);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.addr     = addr;
    r.size     = 3'd2;
    r.len      = len;
    r.burst    = (len != 8'd0) ? 2'd1 : 2'd0;
    r.strobe   = wr ? 4'hF : 4'h0;
    r.data     = addr ^ 32'h0000_5A5A;
    return r;
  endfunction

  function automatic void push_exp(input int m, input logic [31:0] addr, input logic [7:0] len, input int gap);
    exp_t e;
    e.m    = m;
    e.addr = addr;
    e.len  = len;
    e.gap  = gap;
    exp_q.push_back(e);
  endfunction

  // Wait (bounded) for master m's last-beat handshake, then drop its request
  task automatic wait_done(input int m);
    int c;
    for (c = 0; c < BOUND; c++) begin
      if (oresps[m].ready && oresps[m].last) break;
      @(negedge clk);
    end
    check_eq("done_in_bound", 128'(c < BOUND), 128'(1'b1));
    @(posedge clk);
    #1;
    ireqs[m] = '0;
  endtask

  task automatic master_txn(input int m, input logic [31:0] addr, input logic wr, input logic [7:0] len, input int delay);
    repeat (delay) @(posedge clk);
    @(posedge clk);
    #1;
    ireqs[m] = mk_req(addr, wr, len);
    wait_done(m);
  endtask

  // Memory-side model: one beat per cycle, or every other cycle in gap mode
  initial begin : mem_model
    int beat;
    bit phase;
    beat  = 0;
    phase = 1'b0;
    iresp = '{ready: 1'b0, last: 1'b1, data: 32'hDEAD_BEEF};
    forever begin
      @(posedge clk);
      #2;
      if (!resetn) begin
        beat  = 0;
        phase = 1'b0;
        iresp = '{ready: 1'b0, last: 1'b1, data: 32'hDEAD_BEEF};
      end else begin
        if (iresp.ready) begin
          if (iresp.last) beat = 0;
          else beat++;
        end
        if (oreq.valid) begin
          phase      = gap_mode ? ~phase : 1'b1;
          iresp.ready = phase;
          iresp.last  = (beat == int'(oreq.len));
          iresp.data  = oreq.addr ^ 32'hD000_0000 ^ 32'(beat);
        end else begin
          phase = 1'b0;
          iresp = '{ready: 1'b0, last: 1'b1, data: 32'hDEAD_BEEF};
        end
      end
    end
  end

  // Bus monitor: pops the scoreboard on each grant, checks hold, routing, beat count and gap
  initial begin : monitor
    bit   in_txn;
    exp_t cur;
    int   beats;
    int   cyc;
    int   last_end;
    in_txn   = 1'b0;
    beats    = 0;
    cyc      = 0;
    last_end = -1000;
    cur.m    = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        in_txn = 1'b0;
      end else if (oreq.valid) begin
        if (!in_txn) begin
          if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 128'(exp_q.size()), 128'(1));
          end else begin
            cur = exp_q.pop_front();
            check_eq("grant_addr", 128'(oreq.addr), 128'(cur.addr));
            check_eq("grant_len", 128'(oreq.len), 128'(cur.len));
            if (cur.gap >= 0) check_eq("idle_gap", 128'(cyc - last_end), 128'(cur.gap));
          end
          in_txn = 1'b1;
          beats  = 0;
        end else begin
          check_eq("hold_addr", 128'(oreq.addr), 128'(cur.addr));
        end
        for (int j = 0; j < NM; j++) begin
          if (j == cur.m) check_eq("route_owner", 128'(oresps[j]), 128'(iresp));
          else check_eq("route_other", 128'(oresps[j]), 128'(0));
        end
        if (iresp.ready) begin
          beats++;
          if (iresp.last) begin
            check_eq("beat_count", 128'(beats), 128'(int'(cur.len) + 1));
            in_txn   = 1'b0;
            last_end = cyc;
          end
        end
      end else begin
        if (in_txn) check_eq("owner_held", 128'(oreq.valid), 128'(1'b1));
        for (int j = 0; j < NM; j++) check_eq("idle_resp", 128'(oresps[j]), 128'(0));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", check_cnt, err_cnt);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int beats;
    resetn   = 1'b0;
    ireqs[0] = mk_req(32'h1000_0000, 1'b0, 8'd3);
    ireqs[1] = mk_req(32'h2000_0040, 1'b1, 8'd0);
    repeat (3) @(negedge clk);
    check_eq("rst_oreq", 128'(oreq), 128'(0));
    check_eq("rst_resp0", 128'(oresps[0]), 128'(0));
    check_eq("rst_resp1", 128'(oresps[1]), 128'(0));

    // Both valid at reset release: m0 first, m1 after one idle cycle
    push_exp(0, 32'h1000_0000, 8'd3, -1);
    push_exp(1, 32'h2000_0040, 8'd0, 2);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check_eq("s2_arb_latency", 128'(oreq.valid), 128'(1'b0));
    fork
      wait_done(0);
      wait_done(1);
    join
`ifdef CBUS_ARB_PERF_EN
    check_eq("perf_txns", 128'(perf_txns), 128'(2));
    check_eq("perf_wait", 128'(perf_wait), 128'(4 + 2));
`endif

    // Single read from m1
    push_exp(1, 32'h8000_0000, 8'd0, -1);
    @(posedge clk);
    #1;
    ireqs[1] = mk_req(32'h8000_0000, 1'b0, 8'd0);
    @(negedge clk);
    check_eq("t1_valid_cyc0", 128'(oreq.valid), 128'(1'b0));
    @(negedge clk);
    check_eq("t1_valid_cyc1", 128'(oreq.valid), 128'(1'b1));
    check_eq("t1_data", 128'(oresps[1].data), 128'(32'h5000_0000));
    check_eq("t1_m0_idle", 128'(oresps[0]), 128'(0));
    wait_done(1);

    // 16-beat write burst with ready every other cycle; m0 arrives mid-burst
    gap_mode = 1'b1;
    push_exp(1, 32'h3000_0000, 8'd15, -1);
    push_exp(0, 32'h1000_0100, 8'd0, 2);
    fork
      master_txn(1, 32'h3000_0000, 1'b1, 8'd15, 0);
      master_txn(0, 32'h1000_0100, 1'b0, 8'd0, 6);
    join
    gap_mode = 1'b0;

    // Fairness: both request continuously, m1 holds priority after m0 went last
    for (int k = 0; k < 10; k++) begin
      lens[k] = 8'($urandom_range(0, 3));
      push_exp((k % 2 == 0) ? 1 : 0, 32'h4000_0000 + 32'(k * 16), lens[k], (k == 0) ? -1 : 2);
    end
    fork
      begin
        for (int k = 0; k < 10; k += 2) master_txn(1, 32'h4000_0000 + 32'(k * 16), 1'b0, lens[k], 0);
      end
      begin
        for (int k = 1; k < 10; k += 2) master_txn(0, 32'h4000_0000 + 32'(k * 16), 1'b1, lens[k], 0);
      end
    join

    // Leave rr_ptr at 1, then reset in the middle of an 8-beat burst
    push_exp(0, 32'h1000_0200, 8'd0, -1);
    master_txn(0, 32'h1000_0200, 1'b0, 8'd0, 0);
    push_exp(1, 32'h5000_0000, 8'd7, -1);
    @(posedge clk);
    #1;
    ireqs[1] = mk_req(32'h5000_0000, 1'b1, 8'd7);
    beats = 0;
    for (int c = 0; c < BOUND && beats < 5; c++) begin
      @(negedge clk);
      if (oresps[1].ready) beats++;
    end
    check_eq("t5_reach_beat5", 128'(beats), 128'(5));
    #1;
    resetn   = 1'b0;
    ireqs[1] = '0;
    #1;
    check_eq("t5_rst_oreq", 128'(oreq), 128'(0));
    check_eq("t5_rst_resp0", 128'(oresps[0]), 128'(0));
    check_eq("t5_rst_resp1", 128'(oresps[1]), 128'(0));
    repeat (2) @(negedge clk);

    // After release rr_ptr is 0 again, so m0 wins the tie
    push_exp(0, 32'h1000_0300, 8'd1, -1);
    push_exp(1, 32'h2000_0300, 8'd0, 2);
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    ireqs[0] = mk_req(32'h1000_0300, 1'b0, 8'd1);
    ireqs[1] = mk_req(32'h2000_0300, 1'b0, 8'd0);
    @(negedge clk);
    check_eq("t5_idle_after_rst", 128'(oreq.valid), 128'(1'b0));
    fork
      wait_done(0);
      wait_done(1);
    join

    repeat (3) @(negedge clk);
    check_eq("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
